ttl_74x153: RTL and testbench

TTL_74X153 -- requirements
Module: ttl_74x153

---
 rtl/ttl_74x153.sv | 49 ++++
 tb/tb_ttl_74x153.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ttl_74x153.sv
// rtl/ttl_74x153.sv - dual 4-to-1 multiplexer with shared selects, active-low enables, registered outputs
module ttl_74x153 (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic enable1,
    input  logic enable2,
    input  logic c10,
    input  logic c11,
    input  logic c12,
    input  logic c13,
    input  logic c20,
    input  logic c21,
    input  logic c22,
    input  logic c23,
    output logic y1,
    output logic y2
);

    logic [1:0] sel;
    logic [3:0] c1;
    logic [3:0] c2;
    logic       mux1;
    logic       mux2;

    assign sel = {b, a};
    assign c1  = {c13, c12, c11, c10};
    assign c2  = {c23, c22, c21, c20};

    // A high strobe forces the section low regardless of select or data
    always_comb begin
        mux1 = 1'b0;
        mux2 = 1'b0;
        if (!enable1) mux1 = c1[sel];
        if (!enable2) mux2 = c2[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y1 <= 1'b0;
            y2 <= 1'b0;
        end else begin
            y1 <= mux1;
            y2 <= mux2;
        end
    end

endmodule

// File: tb/tb_ttl_74x153.sv
// tb/tb_ttl_74x153.sv - self-checking bench for ttl_74x153
module tb_ttl_74x153;

    logic clk = 1'b0;
    logic rst;
    logic a, b, enable1, enable2;
    logic c10, c11, c12, c13, c20, c21, c22, c23;
    logic y1, y2;

    int checks = 0;
    int errors = 0;

    ttl_74x153 dut (
        .clk(clk), .rst(rst), .a(a), .b(b),
        .enable1(enable1), .enable2(enable2),
        .c10(c10), .c11(c11), .c12(c12), .c13(c13),
        .c20(c20), .c21(c21), .c22(c22), .c23(c23),
        .y1(y1), .y2(y2)
    );

    always #5 clk = ~clk;

    function automatic logic model(input logic en_n, input logic [3:0] c,
                                   input logic bb, input logic aa);
        int idx;
        idx = 2 * int'(bb) + int'(aa);
        if (en_n) return 1'b0;
        return logic'((int'(c) >> idx) % 2);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic aa, input logic bb, input logic e1, input logic e2,
                         input logic [3:0] d1, input logic [3:0] d2);
        a = aa; b = bb; enable1 = e1; enable2 = e2;
        {c13, c12, c11, c10} = d1;
        {c23, c22, c21, c20} = d2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [11:0] v;
    logic [3:0]  d1, d2;
    logic        ex1, ex2;
    int          stride, offset;

    initial begin
        // reset with everything pushing outputs high
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        tick; check("reset_y1_e1", y1, 1'b0); check("reset_y2_e1", y2, 1'b0);
        tick; check("reset_y1_e2", y1, 1'b0); check("reset_y2_e2", y2, 1'b0);

        // select sweep; first non-reset edge must already show the mux result
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            drive(logic'(s % 2), logic'(s / 2), 1'b0, 1'b1, 4'b1010, 4'hF);
            check("sweep_hold_y1", y1, (s == 0) ? 1'b0 : logic'((s - 1) % 2));
            tick;
            check("sweep_y1", y1, logic'(s % 2));
            check("sweep_y2_off", y2, 1'b0);
        end

        // enable gating
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        tick; check("gate_a_y1", y1, 1'b0); check("gate_a_y2", y2, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF);
        tick; check("gate_b_y1", y1, 1'b1); check("gate_b_y2", y2, 1'b0);

        // section independence
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b1110);
        tick; check("indep0_y1", y1, 1'b1); check("indep0_y2", y2, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b1110);
        tick; check("indep3_y1", y1, 1'b0); check("indep3_y2", y2, 1'b1);

        // reset raised between edges must not touch outputs until the edge
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        tick; check("pre_async_y1", y1, 1'b1); check("pre_async_y2", y2, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_y1", y1, 1'b1); check("async_y2", y2, 1'b1);
        tick; check("sync_rst_y1", y1, 1'b0); check("sync_rst_y2", y2, 1'b0);
        rst = 1'b0;

        // exhaustive in a random permutation order, with a one-edge reset mid-run
        stride = 2 * int'($urandom_range(0, 2047)) + 1;
        offset = int'($urandom_range(0, 4095));
        for (int i = 0; i < 4096; i++) begin
            v  = 12'((i * stride + offset) % 4096);
            d1 = v[7:4];
            d2 = v[3:0];
            drive(v[11], v[10], v[9], v[8], d1, d2);
            if (i == 2000) begin
                rst = 1'b1;
                ex1 = 1'b0;
                ex2 = 1'b0;
            end else begin
                rst = 1'b0;
                ex1 = model(v[9], d1, v[10], v[11]);
                ex2 = model(v[8], d2, v[10], v[11]);
            end
            tick;
            check(i == 2000 ? "mid_rst_y1" : "exh_y1", y1, ex1);
            check(i == 2000 ? "mid_rst_y2" : "exh_y2", y2, ex2);
        end
        rst = 1'b0;

        // extra random traffic with occasional reset edges
        for (int i = 0; i < 500; i++) begin
            v   = 12'($urandom);
            rst = ($urandom_range(0, 15) == 0);
            d1  = v[7:4];
            d2  = v[3:0];
            drive(v[11], v[10], v[9], v[8], d1, d2);
            ex1 = rst ? 1'b0 : model(v[9], d1, v[10], v[11]);
            ex2 = rst ? 1'b0 : model(v[8], d2, v[10], v[11]);
            tick;
            check("rand_y1", y1, ex1);
            check("rand_y2", y2, ex2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
